// File: rtl/cve2_fetch_aligner.sv
// Fetch aligner: turns word-aligned fetch words into one 16/32-bit
// instruction per handshake, including straddles and odd branch targets.
module cve2_fetch_aligner #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    output logic [31:0] fetch_addr_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic        is_compressed_o,
    output logic        instr_err_o
);

    logic [31:0] word_q;
    logic        word_vld_q;
    logic        half_q;
    logic        err_q;
    logic [31:0] pc_q;
    logic [31:0] faddr_q;

    logic        lo_cmp;
    logic        hi_cmp;
    logic        last_use;
    logic        straddle;
    logic        fetch_hs;
    logic        instr_hs;
    logic [31:0] instr_rdata;

    assign lo_cmp = word_q[1:0] != 2'b11;
    assign hi_cmp = word_q[17:16] != 2'b11;

    always_comb begin
        instr_rdata = word_q;
        last_use    = 1'b1;
        straddle    = 1'b0;
        unique case (1'b1)
            (!half_q && lo_cmp): begin
                instr_rdata = {16'h0000, word_q[15:0]};
                last_use    = 1'b0;
            end
            (!half_q && !lo_cmp): begin
                instr_rdata = word_q;
            end
            (half_q && hi_cmp): begin
                instr_rdata = {16'h0000, word_q[31:16]};
            end
            (half_q && !hi_cmp): begin
                // upper half of the instruction comes straight from the bus
                instr_rdata = {fetch_rdata_i[15:0], word_q[31:16]};
                straddle    = word_vld_q;
            end
        endcase
    end

    assign instr_rdata_o   = instr_rdata;
    assign is_compressed_o = instr_rdata[1:0] != 2'b11;
    assign instr_pc_o      = pc_q;
    assign fetch_addr_o    = faddr_q;

    assign instr_valid_o = word_vld_q & ~branch_i & ~rst_i
                         & (~straddle | fetch_valid_i);
    assign instr_err_o   = ~rst_i & (err_q | (straddle & fetch_err_i));
    assign fetch_ready_o = ~rst_i & ~branch_i
                         & (~word_vld_q | (instr_ready_i & last_use));

    assign fetch_hs = fetch_valid_i & fetch_ready_o;
    assign instr_hs = instr_valid_o & instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q     <= 32'h0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
            half_q     <= RESET_ADDR[1];
            pc_q       <= RESET_ADDR & 32'hFFFF_FFFE;
            faddr_q    <= RESET_ADDR & 32'hFFFF_FFFC;
        end else if (branch_i) begin
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
            half_q     <= branch_addr_i[1];
            pc_q       <= branch_addr_i & 32'hFFFF_FFFE;
            faddr_q    <= branch_addr_i & 32'hFFFF_FFFC;
        end else begin
            if (instr_hs) begin
                pc_q <= pc_q + (is_compressed_o ? 32'd2 : 32'd4);
                if (!last_use) begin
                    half_q <= 1'b1;
                end else if (!fetch_hs) begin
                    word_vld_q <= 1'b0;
                    half_q     <= 1'b0;
                end
            end
            if (fetch_hs) begin
                word_q     <= fetch_rdata_i;
                word_vld_q <= 1'b1;
                err_q      <= fetch_err_i;
                faddr_q    <= faddr_q + 32'd4;
                // an empty buffer keeps half_q so odd branch targets skip the low half
                if (straddle)
                    half_q <= 1'b1;
                else if (word_vld_q)
                    half_q <= 1'b0;
            end
        end
    end

endmodule
